pulse_int_seq: RTL
==================

# pulse_int_seq

Sequencer and configuration controller for the pulse integrator in the SAR receive chain. Sits between the ADC sample stream and the pulse integrator. Aligns the stream to the radar pulse trigger and forwards exactly `n_samples` beats per pulse. Shadows the integration configuration and applies it only at integration-frame boundaries, resets the integrator and its accumulation FIFO on every reconfiguration, and reports frame completion and errors to the PS.

## Interface
Parameters:
- AXIS_DATA_WIDTH, 32, sample width
- CNT_WIDTH, 16, width of all configuration fields
- FLUSH_CYCLES, 4, integrator-reset hold length in cycles (≥2)

Ports:
- aclk  in  1  system clock; one clock domain
- aresetn  in  1  synchronous, active-low reset
- s_axis_tdata  in  AXIS_DATA_WIDTH  ADC samples
- s_axis_tvalid  in  1  ADC valid
- s_axis_tready  out  1  constant 1; ADC is never back-pressured
- m_axis_tdata  out  AXIS_DATA_WIDTH  samples to integrator
- m_axis_tvalid  out  1  gated valid to integrator
- trigger  in  1  pulse-start strobe, level, synchronous to aclk
- cfg_enable  in  1  run enable
- cfg_update  in  1  one-cycle strobe to latch the cfg_* fields
- cfg_n_pulses, cfg_n_samples, cfg_start_index, cfg_end_index  in  CNT_WIDTH each  requested configuration
- n_pulses, n_samples, start_index, end_index  out  CNT_WIDTH each  active (shadow) configuration to integrator
- int_aresetn  out  1  active-low reset for integrator and accumulation FIFO
- busy  out  1  high when not in IDLE
- cfg_error  out  1  sticky invalid-config flag
- irq_frame_done  out  1  one-cycle frame-complete pulse
- frame_count  out  32  completed frames
- overrun_count  out  16  triggers lost while in PULSE; saturating

## Operation
- States:
  - IDLE
  - FLUSH: int_aresetn low for FLUSH_CYCLES cycles
  - ARM: wait for trigger
  - PULSE: forward samples
- Transitions:
  - IDLE→FLUSH on cfg_enable=1.
  - FLUSH→ARM after the count, or →IDLE if cfg_enable=0.
  - ARM→PULSE on trigger rising edge.
  - PULSE→ARM on the last beat.
  - Any state except IDLE/FLUSH → FLUSH→IDLE on cfg_enable=0; a partial frame is discarded.
- Trigger edge: trigger=1 with previously registered trigger=0.
- Sample counter: 1-based; counts beats with s_axis_tvalid=1 in PULSE. Last beat when the counter equals n_samples.
- Pulse counter: increments on each last beat. When it equals n_pulses:
  - irq_frame_done=1 for one cycle
  - frame_count+1
  - pulse counter cleared
- m_axis_tdata = s_axis_tdata; m_axis_tvalid = s_axis_tvalid & (state==PULSE). Beats outside PULSE are dropped.
- Config validation: valid iff n_pulses≥1, n_samples≥1, and 1≤start≤end≤n_samples.
  - cfg_update with a valid set stores it as pending and clears cfg_error.
  - cfg_update with an invalid set sets cfg_error and leaves the pending set unchanged.
- Pending config is applied:
  - in IDLE, immediately;
  - while running, only on the frame-done cycle; the sequencer then goes to FLUSH instead of ARM.
- A trigger edge during PULSE is ignored and increments overrun_count, saturating at 0xFFFF.
- Counters are 32-bit unsigned. frame_count wraps modulo 2^32.

## Timing
- Reset values:
  - m_axis_tvalid=0, int_aresetn=0, busy=0, cfg_error=0, irq_frame_done=0
  - frame_count=0, overrun_count=0
  - shadow config n_pulses=n_samples=start_index=end_index=1
  - no pending config
- Reset mid-operation returns all outputs to these values on the next edge; no partial frame is reported.
- Forwarding has zero latency, combinational from s_axis.
- Trigger edge at cycle t → PULSE at t+1 → first forwarded beat possible at t+1.
- int_aresetn is low exactly FLUSH_CYCLES cycles in FLUSH, and also throughout IDLE.
- Shadow outputs change only on the cycle after application and stay stable for the whole frame.
- Simultaneous events:
  - trigger edge on the last-beat cycle: counted as the next pulse start, going straight to PULSE, unless that beat ends a frame with pending config (edge dropped, not counted as overrun).
  - cfg_update on the frame-done cycle: applied at that boundary.
  - cfg_enable=0 on the frame-done cycle: irq_frame_done still asserts, then FLUSH→IDLE.

## Configuration
- Macro `PULSE_INT_SEQ_TIMEOUT_EN` enables the trigger watchdog.
  - Adds parameter TIMEOUT_CYCLES (default 1_000_000) and output trig_timeout (sticky, reset 0).
  - With it: a 32-bit counter, cleared on every trigger edge, runs in ARM. Reaching TIMEOUT_CYCLES sets trig_timeout and forces FLUSH→ARM, discarding the partial frame.
  - trig_timeout clears on the next cfg_update.
- Without it: no counter, no port; ARM waits indefinitely.

## Structure
- Package pulse_int_pkg holds:
  - state enum (IDLE, FLUSH, ARM, PULSE)
  - default CNT_WIDTH
  - shadow-config reset constants
  - config-validation function
- One sub-module, pulse_int_cfg_shadow, owns validation, the pending register, cfg_error and application on an `apply` strobe. The top owns the FSM and counters.

## Test plan
- n_pulses=3, n_samples=8, start=2, end=5; continuous tvalid; triggers every 20 cycles → exactly 24 forwarded beats, then one irq_frame_done cycle and frame_count=1.
- Trigger edge at beat 4 of 8 → ignored, overrun_count=1, pulse still ends at beat 8.
- Valid cfg_update (n_samples=16) mid-frame → shadow unchanged until frame done, then int_aresetn low 4 cycles, then n_samples=16.
- cfg_update with start=6, end=5 → cfg_error=1, shadow and pending unchanged; a subsequent valid update clears cfg_error.
- cfg_enable dropped at beat 3 of pulse 2 → m_axis_tvalid=0 next cycle, FLUSH then IDLE, frame_count unchanged, no irq.
- aresetn low mid-PULSE, and (with the macro, TIMEOUT_CYCLES=100) no trigger for 100 cycles → all reset values restored; trig_timeout=1 followed by FLUSH.

Source files
------------

// File: rtl/pulse_int_pkg.sv
// Shared types, constants and config validation for the pulse integrator sequencer.
package pulse_int_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        ARM   = 2'd2,
        PULSE = 2'd3
    } state_t;

    localparam int unsigned CNT_WIDTH_DEF  = 16;
    localparam int unsigned SHADOW_RST_VAL = 1;

    // Fields are zero-extended to 32 bits by the caller, so CNT_WIDTH must not exceed 32.
    function automatic logic cfg_is_valid(input logic [31:0] np,
                                          input logic [31:0] ns,
                                          input logic [31:0] st,
                                          input logic [31:0] en);
        return (np != 32'd0) && (ns != 32'd0) && (st != 32'd0) &&
               (st <= en) && (en <= ns);
    endfunction

endpackage

// File: rtl/pulse_int_cfg_shadow.sv
// Validates requested configuration, holds one pending set and moves it into the
// active shadow registers on an apply strobe.
module pulse_int_cfg_shadow
    import pulse_int_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
)(
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 cfg_update,
    input  logic [CNT_WIDTH-1:0] cfg_n_pulses,
    input  logic [CNT_WIDTH-1:0] cfg_n_samples,
    input  logic [CNT_WIDTH-1:0] cfg_start_index,
    input  logic [CNT_WIDTH-1:0] cfg_end_index,
    input  logic                 apply,
    output logic                 pending,
    output logic                 cfg_error,
    output logic [CNT_WIDTH-1:0] n_pulses,
    output logic [CNT_WIDTH-1:0] n_samples,
    output logic [CNT_WIDTH-1:0] start_index,
    output logic [CNT_WIDTH-1:0] end_index
);

    localparam logic [CNT_WIDTH-1:0] RST_V = CNT_WIDTH'(SHADOW_RST_VAL);

    logic                 r_pend_vld;
    logic [CNT_WIDTH-1:0] r_pend_np, r_pend_ns, r_pend_st, r_pend_en;
    logic [CNT_WIDTH-1:0] r_np, r_ns, r_st, r_en;
    logic                 r_err;
    logic                 w_req_ok;
    logic                 w_take;

    assign w_req_ok = cfg_is_valid(32'(cfg_n_pulses), 32'(cfg_n_samples),
                                   32'(cfg_start_index), 32'(cfg_end_index));
    assign w_take   = cfg_update & w_req_ok;
    // An update arriving on the apply cycle bypasses the pending register.
    assign pending  = r_pend_vld | w_take;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_pend_vld <= 1'b0;
            r_pend_np  <= RST_V;
            r_pend_ns  <= RST_V;
            r_pend_st  <= RST_V;
            r_pend_en  <= RST_V;
            r_np       <= RST_V;
            r_ns       <= RST_V;
            r_st       <= RST_V;
            r_en       <= RST_V;
            r_err      <= 1'b0;
        end else begin
            if (cfg_update) begin
                if (w_req_ok) begin
                    r_pend_np  <= cfg_n_pulses;
                    r_pend_ns  <= cfg_n_samples;
                    r_pend_st  <= cfg_start_index;
                    r_pend_en  <= cfg_end_index;
                    r_pend_vld <= 1'b1;
                    r_err      <= 1'b0;
                end else begin
                    r_err      <= 1'b1;
                end
            end
            if (apply) begin
                r_np       <= w_take ? cfg_n_pulses    : r_pend_np;
                r_ns       <= w_take ? cfg_n_samples   : r_pend_ns;
                r_st       <= w_take ? cfg_start_index : r_pend_st;
                r_en       <= w_take ? cfg_end_index   : r_pend_en;
                r_pend_vld <= 1'b0;
            end
        end
    end

    assign cfg_error   = r_err;
    assign n_pulses    = r_np;
    assign n_samples   = r_ns;
    assign start_index = r_st;
    assign end_index   = r_en;

endmodule

// File: rtl/pulse_int_seq.sv
// Pulse integrator sequencer: trigger alignment, beat gating, frame counting and
// config application. Define PULSE_INT_SEQ_TIMEOUT_EN to add the ARM-state trigger watchdog.
module pulse_int_seq
    import pulse_int_pkg::*;
#(
    parameter int unsigned AXIS_DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH       = CNT_WIDTH_DEF,
    parameter int unsigned FLUSH_CYCLES    = 4
`ifdef PULSE_INT_SEQ_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES  = 1_000_000
`endif
)(
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       trigger,
    input  logic                       cfg_enable,
    input  logic                       cfg_update,
    input  logic [CNT_WIDTH-1:0]       cfg_n_pulses,
    input  logic [CNT_WIDTH-1:0]       cfg_n_samples,
    input  logic [CNT_WIDTH-1:0]       cfg_start_index,
    input  logic [CNT_WIDTH-1:0]       cfg_end_index,
    output logic [CNT_WIDTH-1:0]       n_pulses,
    output logic [CNT_WIDTH-1:0]       n_samples,
    output logic [CNT_WIDTH-1:0]       start_index,
    output logic [CNT_WIDTH-1:0]       end_index,
    output logic                       int_aresetn,
    output logic                       busy,
    output logic                       cfg_error,
    output logic                       irq_frame_done,
    output logic [31:0]                frame_count,
    output logic [15:0]                overrun_count
`ifdef PULSE_INT_SEQ_TIMEOUT_EN
    ,
    output logic                       trig_timeout
`endif
);

    state_t      r_state, w_state_nxt;
    logic        r_trig_d;
    logic [31:0] r_samp_cnt, r_pulse_cnt, r_frame_cnt, r_flush_cnt;
    logic [15:0] r_ovr_cnt;
    logic        r_irq;

    logic w_edge, w_beat, w_last, w_frame_done, w_flush_done;
    logic w_pending, w_apply, w_timeout;

    assign w_edge       = trigger & ~r_trig_d;
    assign w_beat       = (r_state == PULSE) & s_axis_tvalid;
    assign w_last       = w_beat & ((r_samp_cnt + 32'd1) == 32'(n_samples));
    assign w_frame_done = w_last & ((r_pulse_cnt + 32'd1) == 32'(n_pulses));
    assign w_flush_done = (r_state == FLUSH) & (r_flush_cnt == 32'(FLUSH_CYCLES - 1));
    assign w_apply      = w_pending & ((r_state == IDLE) | w_frame_done);

    pulse_int_cfg_shadow #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_shadow (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .cfg_update      (cfg_update),
        .cfg_n_pulses    (cfg_n_pulses),
        .cfg_n_samples   (cfg_n_samples),
        .cfg_start_index (cfg_start_index),
        .cfg_end_index   (cfg_end_index),
        .apply           (w_apply),
        .pending         (w_pending),
        .cfg_error       (cfg_error),
        .n_pulses        (n_pulses),
        .n_samples       (n_samples),
        .start_index     (start_index),
        .end_index       (end_index)
    );

`ifdef PULSE_INT_SEQ_TIMEOUT_EN
    logic [31:0] r_to_cnt;
    logic        r_trig_to;

    assign w_timeout = (r_state == ARM) & ~w_edge & (r_to_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_to_cnt  <= '0;
            r_trig_to <= 1'b0;
        end else begin
            if ((r_state != ARM) || w_edge || w_timeout)
                r_to_cnt <= '0;
            else
                r_to_cnt <= r_to_cnt + 32'd1;
            if (w_timeout)
                r_trig_to <= 1'b1;
            else if (cfg_update)
                r_trig_to <= 1'b0;
        end
    end

    assign trig_timeout = r_trig_to;
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (cfg_enable) w_state_nxt = FLUSH;
            FLUSH: if (w_flush_done) w_state_nxt = cfg_enable ? ARM : IDLE;
            ARM: begin
                if (!cfg_enable || w_timeout) w_state_nxt = FLUSH;
                else if (w_edge)              w_state_nxt = PULSE;
            end
            PULSE: begin
                // Frame end with a pending config flushes; the coincident trigger edge is dropped.
                if (!cfg_enable)                      w_state_nxt = FLUSH;
                else if (w_last) begin
                    if (w_frame_done && w_pending)    w_state_nxt = FLUSH;
                    else if (w_edge)                  w_state_nxt = PULSE;
                    else                              w_state_nxt = ARM;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state     <= IDLE;
            r_trig_d    <= 1'b0;
            r_samp_cnt  <= '0;
            r_pulse_cnt <= '0;
            r_frame_cnt <= '0;
            r_flush_cnt <= '0;
            r_ovr_cnt   <= '0;
            r_irq       <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_trig_d <= trigger;
            r_irq    <= w_frame_done;

            if ((r_state == FLUSH) && !w_flush_done) r_flush_cnt <= r_flush_cnt + 32'd1;
            else                                     r_flush_cnt <= '0;

            if (w_last || (r_state != PULSE)) r_samp_cnt <= '0;
            else if (w_beat)                  r_samp_cnt <= r_samp_cnt + 32'd1;

            if ((r_state == IDLE) || (r_state == FLUSH) || w_frame_done) r_pulse_cnt <= '0;
            else if (w_last)                                            r_pulse_cnt <= r_pulse_cnt + 32'd1;

            if (w_frame_done) r_frame_cnt <= r_frame_cnt + 32'd1;

            if ((r_state == PULSE) && w_edge && !w_last && (r_ovr_cnt != 16'hFFFF))
                r_ovr_cnt <= r_ovr_cnt + 16'd1;
        end
    end

    assign s_axis_tready  = 1'b1;
    assign m_axis_tdata   = s_axis_tdata;
    assign m_axis_tvalid  = s_axis_tvalid & (r_state == PULSE);
    assign int_aresetn    = (r_state == ARM) | (r_state == PULSE);
    assign busy           = (r_state != IDLE);
    assign irq_frame_done = r_irq;
    assign frame_count    = r_frame_cnt;
    assign overrun_count  = r_ovr_cnt;

endmodule
